mismatch_monitor: RTL and testbench
===================================

MISMATCH_MONITOR -- requirements
Module: mismatch_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of all statistics counters.
REQ-002 Parameter WINDOW, default 200: number of enabled samples per run, 1..2^CNT_W-1.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  pulse; clears statistics and begins a run.
REQ-006 en  in  1  sample qualifier; a sample is taken only when en=1 in RUN.
REQ-007 z_ref  in  1  golden response bit.
REQ-008 z_dut  in  1  device-under-test response bit.
REQ-009 busy  out  1  high in RUN.
REQ-010 done  out  1  high in DONE.
REQ-011 samples  out  CNT_W  enabled samples taken this run.
REQ-012 errors  out  CNT_W  mismatching samples this run, saturating.
REQ-013 first_err  out  CNT_W  samples value at first mismatch.
REQ-014 first_vld  out  1  first_err holds a valid capture.
REQ-015 mismatch  out  1  registered copy of (z_ref != z_dut) for the last sample.

Function
REQ-016 FSM states IDLE, RUN, DONE; encoding in shared package.
REQ-017 IDLE -> RUN on start=1; DONE -> RUN on start=1; RUN -> RUN (restart) on start=1.
REQ-018 Any start cycle clears samples, errors, first_err, first_vld, mismatch; no sample taken that cycle.
REQ-019 In RUN with en=1 and start=0: samples += 1; mismatch <= (z_ref != z_dut).
REQ-020 Same sample, mismatch true: errors += 1 unless all-ones (saturate, no wrap).
REQ-021 Same sample, mismatch true and first_vld=0: first_err <= current samples (pre-increment), first_vld <= 1.
REQ-022 RUN -> DONE on the edge where samples transitions to WINDOW; that last sample is counted.
REQ-023 In RUN with en=0: all counters and mismatch hold.
REQ-024 In IDLE and DONE: z_ref, z_dut, en ignored; all statistics hold.
REQ-025 Latency: every output reflects a sample one clock after the sampling edge; no combinational input-to-output path.
REQ-026 busy/done decoded from registered state only.

Reset
REQ-027 reset=1 on an edge: state IDLE; all outputs 0; overrides start and en.
REQ-028 reset mid-RUN discards the run; start is required to resume.

Configuration
REQ-029 Macro MISMATCH_MONITOR_BURST_EN defined: adds outputs cur_burst and max_burst (CNT_W each), counting consecutive mismatching enabled samples; en=0 samples do not break a burst; a matching sample zeroes cur_burst; max_burst tracks maximum, saturating; both cleared by reset and start.
REQ-030 Macro undefined: ports and logic absent; all other behaviour identical.

Structure
REQ-031 Package mismatch_monitor_pkg holds the state enum and the default CNT_W/WINDOW constants.
REQ-032 One sub-module, sat_counter (increment, clear, saturate at all-ones), instantiated for samples, errors and bursts.

Verification
REQ-033 reset, start, 8 enabled samples z_ref=z_dut=0, WINDOW=8 -> done=1 after 8th edge, samples=8, errors=0, first_vld=0.
REQ-034 WINDOW=8, mismatches on samples 3 and 5 (0-based) -> errors=2, first_err=3, first_vld=1, done after 8th sample.
REQ-035 en toggled 1,0,1,0... for 16 cycles with WINDOW=8 -> done after 16th cycle, samples=8; disabled mismatches not counted.
REQ-036 CNT_W=4, WINDOW=15, all samples mismatching -> errors=15 and holds at 15 (no wrap); with burst macro max_burst=15.
REQ-037 reset asserted after 4 samples in RUN -> next edge all outputs 0, IDLE; z activity ignored until start.
REQ-038 start in DONE with errors=5 -> next edge errors=0, first_vld=0, busy=1; start in RUN restarts with same clear.

Source files
------------

// File: rtl/mismatch_monitor_pkg.sv
// Shared types and default sizing for the mismatch monitor.
// Holds the run-state encoding and the default counter width / window length.
package mismatch_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_WINDOW = 200;

endpackage

// File: rtl/mismatch_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over increment so a restart never leaks a stale count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mismatch_monitor.sv
// Compares a golden and a DUT response bit over a window of enabled samples.
// Optional burst statistics (cur_burst/max_burst) are built when MISMATCH_MONITOR_BURST_EN is defined.
module mismatch_monitor
  import mismatch_monitor_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  input  logic             z_ref,
  input  logic             z_dut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err,
  output logic             first_vld,
  output logic             mismatch
`ifdef MISMATCH_MONITOR_BURST_EN
  ,
  output logic [CNT_W-1:0] cur_burst,
  output logic [CNT_W-1:0] max_burst
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t state_q;
  state_t state_d;

  logic             take;
  logic             is_mm;
  logic [CNT_W-1:0] samples_cnt;
  logic [CNT_W-1:0] errors_cnt;
  logic [CNT_W-1:0] first_err_q;
  logic [CNT_W-1:0] first_err_d;
  logic             first_vld_q;
  logic             first_vld_d;
  logic             mismatch_q;
  logic             mismatch_d;

  // A sample is only taken in RUN; a start cycle is reserved for clearing.
  assign take  = (state_q == ST_RUN) && en && !start;
  assign is_mm = z_ref ^ z_dut;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else if (take && (samples_cnt == LAST_IDX)) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  sat_counter #(.W(CNT_W)) u_samples (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (take),
    .count (samples_cnt)
  );

  sat_counter #(.W(CNT_W)) u_errors (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (take && is_mm),
    .count (errors_cnt)
  );

  // first_err latches the pre-increment sample index of the earliest mismatch.
  always_comb begin
    first_err_d = first_err_q;
    first_vld_d = first_vld_q;
    mismatch_d  = mismatch_q;
    if (start) begin
      first_err_d = '0;
      first_vld_d = 1'b0;
      mismatch_d  = 1'b0;
    end else if (take) begin
      mismatch_d = is_mm;
      if (is_mm && !first_vld_q) begin
        first_err_d = samples_cnt;
        first_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_err_q <= '0;
      first_vld_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      first_err_q <= first_err_d;
      first_vld_q <= first_vld_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign samples   = samples_cnt;
  assign errors    = errors_cnt;
  assign first_err = first_err_q;
  assign first_vld = first_vld_q;
  assign mismatch  = mismatch_q;

`ifdef MISMATCH_MONITOR_BURST_EN
  logic [CNT_W-1:0] cur_burst_cnt;
  logic [CNT_W-1:0] cur_burst_nxt;
  logic [CNT_W-1:0] max_burst_q;
  logic [CNT_W-1:0] max_burst_d;

  // Disabled samples leave the burst untouched; only a matching sample ends it.
  sat_counter #(.W(CNT_W)) u_cur_burst (
    .clk   (clk),
    .reset (reset),
    .clr   (start || (take && !is_mm)),
    .inc   (take && is_mm),
    .count (cur_burst_cnt)
  );

  assign cur_burst_nxt = (cur_burst_cnt == {CNT_W{1'b1}}) ? cur_burst_cnt
                                                          : cur_burst_cnt + 1'b1;

  always_comb begin
    max_burst_d = max_burst_q;
    if (start) begin
      max_burst_d = '0;
    end else if (take && is_mm && (cur_burst_nxt > max_burst_q)) begin
      max_burst_d = cur_burst_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_burst_q <= '0;
    end else begin
      max_burst_q <= max_burst_d;
    end
  end

  assign cur_burst = cur_burst_cnt;
  assign max_burst = max_burst_q;
`endif

endmodule

// File: tb/tb_mismatch_monitor.sv
// Randomized plus directed bench for mismatch_monitor, two instances (16-bit/8-sample and 4-bit/15-sample)
// checked against a behavioural model; burst outputs are checked when MISMATCH_MONITOR_BURST_EN is defined.
module tb_mismatch_monitor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic en = 1'b0;
  logic z_ref = 1'b0;
  logic z_dut = 1'b0;

  always #5 clk = ~clk;

  logic        a_busy, a_done, a_first_vld, a_mismatch;
  logic [15:0] a_samples, a_errors, a_first_err;
  logic        b_busy, b_done, b_first_vld, b_mismatch;
  logic [3:0]  b_samples, b_errors, b_first_err;
`ifdef MISMATCH_MONITOR_BURST_EN
  logic [15:0] a_cur_burst, a_max_burst;
  logic [3:0]  b_cur_burst, b_max_burst;
`endif

  mismatch_monitor #(.CNT_W(16), .WINDOW(8)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .en        (en),
    .z_ref     (z_ref),
    .z_dut     (z_dut),
    .busy      (a_busy),
    .done      (a_done),
    .samples   (a_samples),
    .errors    (a_errors),
    .first_err (a_first_err),
    .first_vld (a_first_vld),
    .mismatch  (a_mismatch)
`ifdef MISMATCH_MONITOR_BURST_EN
    ,
    .cur_burst (a_cur_burst),
    .max_burst (a_max_burst)
`endif
  );

  mismatch_monitor #(.CNT_W(4), .WINDOW(15)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .en        (en),
    .z_ref     (z_ref),
    .z_dut     (z_dut),
    .busy      (b_busy),
    .done      (b_done),
    .samples   (b_samples),
    .errors    (b_errors),
    .first_err (b_first_err),
    .first_vld (b_first_vld),
    .mismatch  (b_mismatch)
`ifdef MISMATCH_MONITOR_BURST_EN
    ,
    .cur_burst (b_cur_burst),
    .max_burst (b_max_burst)
`endif
  );

  typedef struct {
    bit running;
    bit finished;
    int samples;
    int errors;
    int first_err;
    bit first_vld;
    bit mm;
    int cur;
    int maxb;
  } model_t;

  model_t ma;
  model_t mb;
  int total = 0;
  int bad = 0;

  // Behavioural reference: run phase as two flags, counts as plain integers clipped to the counter width.
  function automatic model_t modelStep(model_t m, int w, int win, bit r, bit s, bit e, bit zr, bit zd);
    int top;
    model_t n;
    top = (1 << w) - 1;
    n = m;
    if (r) begin
      n = '{default: 0};
    end else if (s) begin
      n = '{default: 0};
      n.running = 1'b1;
    end else if (m.running && e) begin
      n.mm = (zr != zd);
      if (n.mm) begin
        if (!m.first_vld) begin
          n.first_err = m.samples;
          n.first_vld = 1'b1;
        end
        n.errors = (m.errors + 1 > top) ? top : m.errors + 1;
        n.cur    = (m.cur + 1 > top) ? top : m.cur + 1;
        if (n.cur > n.maxb) n.maxb = n.cur;
      end else begin
        n.cur = 0;
      end
      n.samples = m.samples + 1;
      if (n.samples == win) begin
        n.running  = 1'b0;
        n.finished = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkModels();
    checkOutput("a_busy", a_busy, ma.running);
    checkOutput("a_done", a_done, ma.finished);
    checkOutput("a_samples", a_samples, ma.samples);
    checkOutput("a_errors", a_errors, ma.errors);
    checkOutput("a_first_err", a_first_err, ma.first_err);
    checkOutput("a_first_vld", a_first_vld, ma.first_vld);
    checkOutput("a_mismatch", a_mismatch, ma.mm);
    checkOutput("b_busy", b_busy, mb.running);
    checkOutput("b_done", b_done, mb.finished);
    checkOutput("b_samples", b_samples, mb.samples);
    checkOutput("b_errors", b_errors, mb.errors);
    checkOutput("b_first_err", b_first_err, mb.first_err);
    checkOutput("b_first_vld", b_first_vld, mb.first_vld);
    checkOutput("b_mismatch", b_mismatch, mb.mm);
`ifdef MISMATCH_MONITOR_BURST_EN
    checkOutput("a_cur_burst", a_cur_burst, ma.cur);
    checkOutput("a_max_burst", a_max_burst, ma.maxb);
    checkOutput("b_cur_burst", b_cur_burst, mb.cur);
    checkOutput("b_max_burst", b_max_burst, mb.maxb);
`endif
  endtask

  // Inputs change on the falling edge; model advances on the rising edge; outputs are checked 1 unit later.
  task automatic applyStimulus(input bit r, input bit s, input bit e, input bit zr, input bit zd);
    reset = r;
    start = s;
    en    = e;
    z_ref = zr;
    z_dut = zd;
    @(posedge clk);
    ma = modelStep(ma, 16, 8, r, s, e, zr, zd);
    mb = modelStep(mb, 4, 15, r, s, e, zr, zd);
    #1;
    checkModels();
    @(negedge clk);
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    @(negedge clk);

    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_busy", a_busy, 1'b0);
    checkOutput("reset_samples", a_samples, 32'd0);

    // Eight clean samples
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("clean_done", a_done, 1'b1);
    checkOutput("clean_samples", a_samples, 32'd8);
    checkOutput("clean_errors", a_errors, 32'd0);
    checkOutput("clean_first_vld", a_first_vld, 1'b0);

    // Mismatches on samples 3 and 5
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 1, (i == 3 || i == 5) ? 1'b0 : 1'b1);
    checkOutput("two_err_errors", a_errors, 32'd2);
    checkOutput("two_err_first", a_first_err, 32'd3);
    checkOutput("two_err_vld", a_first_vld, 1'b1);
    checkOutput("two_err_done", a_done, 1'b1);

    // Alternating enable; disabled cycles carry mismatches that must be ignored
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, (i % 2) == 0, 0, (i % 2) != 0);
    checkOutput("toggle_done", a_done, 1'b1);
    checkOutput("toggle_samples", a_samples, 32'd8);
    checkOutput("toggle_errors", a_errors, 32'd0);

    // All mismatching on the 4-bit instance
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 18; i++) applyStimulus(0, 0, 1, 0, 1);
    checkOutput("sat_errors", b_errors, 32'd15);
    checkOutput("sat_done", b_done, 1'b1);
`ifdef MISMATCH_MONITOR_BURST_EN
    checkOutput("sat_max_burst", b_max_burst, 32'd15);
`endif

    // Reset mid-run, then ignored activity
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("midrst_samples", a_samples, 32'd0);
    checkOutput("midrst_busy", a_busy, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 1);
    checkOutput("idle_errors", a_errors, 32'd0);

    // Restart from DONE with five errors, then restart mid-run
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, (i < 5) ? 1'b1 : 1'b0);
    checkOutput("five_errors", a_errors, 32'd5);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("restart_errors", a_errors, 32'd0);
    checkOutput("restart_vld", a_first_vld, 1'b0);
    checkOutput("restart_busy", a_busy, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("rerun_errors", a_errors, 32'd0);
    checkOutput("rerun_samples", a_samples, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
